// File: rtl/fp_add_normalize.sv
// Post-add normalize and round-to-nearest-even stage for binary32 addition.
// Normalizes one bit per cycle, then rounds; result held under valid/ready.
module fp_add_normalize (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_in,
  input  logic [7:0]  exp_in,
  input  logic [24:0] mant_in,
  input  logic [2:0]  grs_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign_out,
  output logic [7:0]  exp_out,
  output logic [22:0] mant_out,
  output logic        overflow,
  output logic        zero
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_e;

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [7:0]  exp_q, exp_d;
  logic [24:0] mant_q, mant_d;
  logic        g_q, g_d, r_q, r_d, s_q, s_d;
  logic        denorm_q, denorm_d;
  logic        ovf_q, ovf_d;
  logic        zero_q, zero_d;

  logic        inc;
  logic [24:0] mant_rnd;
  logic [7:0]  exp_inc;

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    g_d      = g_q;
    r_d      = r_q;
    s_d      = s_q;
    denorm_d = denorm_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    inc      = g_q & (r_q | s_q | mant_q[0]);
    mant_rnd = mant_q + {24'b0, inc};
    exp_inc  = exp_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d   = sign_in;
          exp_d    = exp_in;
          mant_d   = mant_in;
          {g_d, r_d, s_d} = grs_in;
          denorm_d = 1'b0;
          ovf_d    = 1'b0;
          zero_d   = 1'b0;
          state_d  = NORM;
        end
      end
      NORM: begin
        if (mant_q == '0 && {g_q, r_q, s_q} == 3'b000) begin
          exp_d   = '0;
          mant_d  = '0;
          zero_d  = 1'b1;
          state_d = DONE;
        end else if (mant_q[24]) begin
          mant_d = mant_q >> 1;
          g_d    = mant_q[0];
          r_d    = g_q;
          s_d    = r_q | s_q;
          if (exp_inc == 8'hFF) begin
            exp_d   = '1;
            mant_d  = '0;
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            exp_d   = exp_inc;
            state_d = ROUND;
          end
        end else if (mant_q[23]) begin
          state_d = ROUND;
        end else if (exp_q == 8'd1) begin
          denorm_d = 1'b1;
          state_d  = ROUND;
        end else begin
          // Guard bit shifts into the LSB; sticky keeps accumulating below it.
          mant_d = {mant_q[23:0], g_q};
          g_d    = r_q;
          r_d    = 1'b0;
          exp_d  = exp_q - 8'd1;
        end
      end
      ROUND: begin
        state_d = DONE;
        if (mant_rnd[24]) begin
          if (exp_inc == 8'hFF) begin
            exp_d  = '1;
            mant_d = '0;
            ovf_d  = 1'b1;
          end else begin
            exp_d  = exp_inc;
            mant_d = mant_rnd >> 1;
          end
        end else begin
          mant_d = mant_rnd;
          // A subnormal that rounds up into the hidden bit becomes the smallest normal.
          if (denorm_q) exp_d = {7'b0, mant_rnd[23]};
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      g_q      <= 1'b0;
      r_q      <= 1'b0;
      s_q      <= 1'b0;
      denorm_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      g_q      <= g_d;
      r_q      <= r_d;
      s_q      <= s_d;
      denorm_q <= denorm_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign sign_out  = sign_q;
  assign exp_out   = exp_q;
  assign mant_out  = mant_q[22:0];
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_fp_add_normalize.sv
// Scoreboard bench for fp_add_normalize: directed vectors push expected
// results; an independent monitor pops and compares on out_valid.
module tb_fp_add_normalize;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [24:0] mant_in;
  logic [2:0]  grs_in;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [7:0]  exp_out;
  logic [22:0] mant_out;
  logic        overflow;
  logic        zero;

  fp_add_normalize dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .grs_in    (grs_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_out  (sign_out),
    .exp_out   (exp_out),
    .mant_out  (mant_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  typedef struct {
    logic        sg;
    logic [7:0]  ex;
    logic [22:0] mn;
    logic        ov;
    logic        zr;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   active = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event (cycle %0d)", name, cyc);
  endtask

  // Monitor: first valid cycle checks latency; every valid cycle checks held values.
  initial begin
    exp_t cur;
    forever begin
      @(negedge clock);
      if (reset) begin
        active = 0;
      end else if (out_valid) begin
        if (!active) begin
          if (q.size() == 0) begin
            note_fail("unexpected_output");
          end else begin
            cur    = q.pop_front();
            active = 1;
            check("latency", cyc - cur.acc + 1, cur.lat);
          end
        end
        if (active) begin
          check("sign_out", {31'b0, sign_out}, {31'b0, cur.sg});
          check("exp_out", {24'b0, exp_out}, {24'b0, cur.ex});
          check("mant_out", {9'b0, mant_out}, {9'b0, cur.mn});
          check("overflow", {31'b0, overflow}, {31'b0, cur.ov});
          check("zero", {31'b0, zero}, {31'b0, cur.zr});
          check("in_ready_busy", {31'b0, in_ready}, 32'd0);
          if (out_ready) active = 0;
        end
      end
    end
  end

  task automatic send(input logic sg, input logic [7:0] ei, input logic [24:0] mi,
                      input logic [2:0] gi, input logic [7:0] ee, input logic [22:0] me,
                      input logic eo, input logic ez, input int lat, input bit push);
    exp_t e;
    int   n;
    @(posedge clock); #1;
    in_valid = 1'b1;
    sign_in  = sg;
    exp_in   = ei;
    mant_in  = mi;
    grs_in   = gi;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      note_fail("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    if (push) begin
      e.sg  = sg;
      e.ex  = ee;
      e.mn  = me;
      e.ov  = eo;
      e.zr  = ez;
      e.lat = lat;
      e.acc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(q.size() == 0 && !active && !out_valid) && n < 100);
    if (n >= 100) note_fail("done_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sign_in   = 1'b0;
    exp_in    = '0;
    mant_in   = '0;
    grs_in    = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("in_ready_in_reset", {31'b0, in_ready}, 32'd0);
    check("out_valid_in_reset", {31'b0, out_valid}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("in_ready_after_reset", {31'b0, in_ready}, 32'd1);
    check("reset_outputs", {out_valid, overflow, zero, sign_out, exp_out, mant_out},
          32'd0);

    // sg, exp, mant, grs, exp_out, mant_out, ovf, zero, latency
    send(0, 8'd127, 25'h0800000, 3'b000, 8'd127, 23'h000000, 0, 0, 3, 1); wait_done();
    send(0, 8'd130, 25'h1800001, 3'b000, 8'd131, 23'h400000, 0, 0, 3, 1); wait_done();
    send(1, 8'd100, 25'h0000100, 3'b000, 8'd85,  23'h000000, 0, 0, 18, 1); wait_done();
    send(0, 8'd10,  25'h0000100, 3'b000, 8'd0,   23'h020000, 0, 0, 12, 1); wait_done();
    send(0, 8'd254, 25'h0FFFFFF, 3'b100, 8'd255, 23'h000000, 1, 0, 3, 1); wait_done();
    send(1, 8'd254, 25'h1000000, 3'b000, 8'd255, 23'h000000, 1, 0, 2, 1); wait_done();
    send(0, 8'd127, 25'h0800001, 3'b100, 8'd127, 23'h000002, 0, 0, 3, 1); wait_done();
    send(0, 8'd127, 25'h0800000, 3'b110, 8'd127, 23'h000001, 0, 0, 3, 1); wait_done();
    send(0, 8'd1,   25'h07FFFFF, 3'b110, 8'd1,   23'h000000, 0, 0, 3, 1); wait_done();
    send(0, 8'd20,  25'h0400000, 3'b101, 8'd19,  23'h000001, 0, 0, 4, 1); wait_done();
    send(0, 8'd3,   25'h0000000, 3'b100, 8'd0,   23'h000002, 0, 0, 5, 1); wait_done();

    // Zero result under backpressure: monitor re-checks the held values each cycle.
    out_ready = 1'b0;
    send(0, 8'd50, 25'h0000000, 3'b000, 8'd0, 23'h000000, 0, 1, 2, 1);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!out_valid && n < 20);
    if (!out_valid) note_fail("zero_valid_timeout");
    repeat (5) @(negedge clock);
    @(posedge clock); #1;
    out_ready = 1'b1;
    wait_done();

    // Reset mid-normalization discards the in-flight result.
    send(0, 8'd200, 25'h0000001, 3'b000, 8'd0, 23'h000000, 0, 0, 0, 0);
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("in_ready_mid_reset", {31'b0, in_ready}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("out_valid_after_abort", {31'b0, out_valid}, 32'd0);
    check("in_ready_after_abort", {31'b0, in_ready}, 32'd1);
    check("exp_out_after_abort", {24'b0, exp_out}, 32'd0);

    send(0, 8'd200, 25'h0000001, 3'b000, 8'd177, 23'h000000, 0, 0, 26, 1); wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
